// File: rtl/pmem_pkg.sv
// ============================================================================
// Module      : pmem_pkg
// Description : Shared types and constants for the L2 physical-memory burst
//               responder (line/beat widths, FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmem_pkg;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int ADDR_WIDTH = 32;
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;

    typedef logic [LINE_WIDTH-1:0] line_t;
    typedef logic [BEAT_WIDTH-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } pmem_state_t;

endpackage : pmem_pkg

`default_nettype wire

// File: rtl/burst_line_buffer.sv
// ============================================================================
// Module      : burst_line_buffer
// Description : Line-wide register built from beat-sized slices, with a
//               whole-line load port, a per-beat write port and a per-beat
//               indexed read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_line_buffer #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH,
    parameter int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [LINE_WIDTH-1:0] load_line,
    input  logic                  beat_we,
    input  logic [IDX_W-1:0]      beat_idx,
    input  logic [BEAT_WIDTH-1:0] beat_wdata,
    output logic [BEAT_WIDTH-1:0] beat_rdata,
    output logic [LINE_WIDTH-1:0] line
);

    logic [BEAT_WIDTH-1:0] r_beat_q [BEATS];

    // A whole-line load takes priority over a single-beat write.
    for (genvar i = 0; i < BEATS; i++) begin : g_beat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_beat_q[i] <= '0;
            end else if (load_en) begin
                r_beat_q[i] <= load_line[i*BEAT_WIDTH +: BEAT_WIDTH];
            end else if (beat_we && (beat_idx == IDX_W'(i))) begin
                r_beat_q[i] <= beat_wdata;
            end
        end

        assign line[i*BEAT_WIDTH +: BEAT_WIDTH] = r_beat_q[i];
    end

    assign beat_rdata = r_beat_q[beat_idx];

endmodule : burst_line_buffer

`default_nettype wire

// File: rtl/pmem_burst_responder.sv
// ============================================================================
// Module      : pmem_burst_responder
// Description : Converts one L2 line read/write into a multi-beat DRAM burst
//               and returns the line or completion with a one-cycle pmem_resp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_burst_responder
    import pmem_pkg::*;
#(
    parameter int LINE_WIDTH = pmem_pkg::LINE_WIDTH,
    parameter int BEAT_WIDTH = pmem_pkg::BEAT_WIDTH,
    parameter int ADDR_WIDTH = pmem_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  dram_read,
    output logic                  dram_write,
    output logic [ADDR_WIDTH-1:0] dram_address,
    output logic [BEAT_WIDTH-1:0] dram_wdata,
    input  logic [BEAT_WIDTH-1:0] dram_rdata,
    input  logic                  dram_resp
);

    localparam int                c_beats     = LINE_WIDTH / BEAT_WIDTH;
    localparam int                c_idx_w     = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam logic [c_idx_w-1:0] c_last_beat = c_idx_w'(c_beats - 1);

    pmem_state_t               r_state;
    pmem_state_t               w_next_state;
    logic [c_idx_w-1:0]        r_beat;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_dram_read;
    logic                      r_dram_write;
    logic                      r_pmem_resp;

    logic                      w_accept_wr;
    logic                      w_accept_rd;
    logic                      w_beat_ack;
    logic                      w_last_beat;
    logic                      w_rd_capture;

    logic [LINE_WIDTH-1:0]     w_unused_wr_line;
    logic [BEAT_WIDTH-1:0]     w_unused_rd_beat;

    assign w_last_beat  = (r_beat == c_last_beat);
    assign w_rd_capture = (r_state == RD_BURST) && dram_resp;

    // Write beats win over reads when both requests arrive together.
    always_comb begin
        w_next_state = r_state;
        w_accept_wr  = 1'b0;
        w_accept_rd  = 1'b0;
        w_beat_ack   = 1'b0;
        case (r_state)
            IDLE: begin
                if (pmem_write) begin
                    w_accept_wr  = 1'b1;
                    w_next_state = WR_BURST;
                end else if (pmem_read) begin
                    w_accept_rd  = 1'b1;
                    w_next_state = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (dram_resp) begin
                    w_beat_ack = 1'b1;
                    if (w_last_beat) begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_addr       <= '0;
            r_dram_read  <= 1'b0;
            r_dram_write <= 1'b0;
            r_pmem_resp  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_dram_read  <= (w_next_state == RD_BURST);
            r_dram_write <= (w_next_state == WR_BURST);
            r_pmem_resp  <= (w_next_state == DONE);
            if (w_accept_wr || w_accept_rd) begin
                r_addr <= pmem_address;
            end
            // The counter parks on the last beat and is only cleared in DONE.
            if (r_state == DONE) begin
                r_beat <= '0;
            end else if (w_beat_ack && !w_last_beat) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    burst_line_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEATS      (c_beats),
        .IDX_W      (c_idx_w)
    ) u_wr_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (w_accept_wr),
        .load_line  (pmem_wdata),
        .beat_we    (1'b0),
        .beat_idx   (r_beat),
        .beat_wdata ('0),
        .beat_rdata (dram_wdata),
        .line       (w_unused_wr_line)
    );

    burst_line_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEATS      (c_beats),
        .IDX_W      (c_idx_w)
    ) u_rd_holder (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (1'b0),
        .load_line  ('0),
        .beat_we    (w_rd_capture),
        .beat_idx   (r_beat),
        .beat_wdata (dram_rdata),
        .beat_rdata (w_unused_rd_beat),
        .line       (pmem_rdata)
    );

    assign pmem_resp    = r_pmem_resp;
    assign dram_read    = r_dram_read;
    assign dram_write   = r_dram_write;
    assign dram_address = r_addr;

endmodule : pmem_burst_responder

`default_nettype wire

// File: tb/tb_pmem_burst_responder.sv
// ============================================================================
// Module      : tb_pmem_burst_responder
// Description : Randomised scoreboard bench with a DRAM memory model and an
//               L2 requester for pmem_burst_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmem_burst_responder;
    import pmem_pkg::*;

    localparam int MAX_WAIT = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pmem_read, pmem_write;
    logic [31:0] pmem_address;
    line_t       pmem_wdata, pmem_rdata;
    logic        pmem_resp;
    logic        dram_read, dram_write;
    logic [31:0] dram_address;
    beat_t       dram_wdata, dram_rdata;
    logic        dram_resp;

    pmem_burst_responder #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .dram_read    (dram_read),
        .dram_write   (dram_write),
        .dram_address (dram_address),
        .dram_wdata   (dram_wdata),
        .dram_rdata   (dram_rdata),
        .dram_resp    (dram_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  is_write;
        line_t line;
    } exp_t;

    exp_t        exp_q[$];
    line_t       mem [logic [31:0]];
    line_t       last_rd = '0;
    int          errors = 0;
    int          checks = 0;

    logic        cur_is_write = 1'b0;
    logic [31:0] cur_addr = '0;
    line_t       cur_wdata = '0;
    line_t       cur_line = '0;
    int          k = 0;
    int          ack_mode = 1;
    int          ack_limit = BEATS;
    int          cyc = 0;

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < LINE_WIDTH / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic line_t mem_get(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = rand_line();
        return mem[a];
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // DRAM model: acknowledges beats per ack_mode and checks the burst it sees.
    bit ack;
    initial begin
        dram_resp  = 1'b0;
        dram_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                k         = 0;
                dram_resp = 1'b0;
            end else if (dram_read || dram_write) begin
                case (ack_mode)
                    0:       ack = ($urandom_range(0, 1) == 1);
                    2:       ack = (cyc % 3 == 0);
                    default: ack = 1'b1;
                endcase
                if (k >= ack_limit) ack = 1'b0;
                dram_resp  = ack;
                dram_rdata = cur_line[k*BEAT_WIDTH +: BEAT_WIDTH];
                if (ack) begin
                    check_val("dram_address", 64'(dram_address), 64'(cur_addr));
                    check_val("burst_dir", {62'd0, dram_read, dram_write},
                              {62'd0, !cur_is_write, cur_is_write});
                    if (cur_is_write)
                        check_val($sformatf("wr_beat%0d", k), dram_wdata,
                                  cur_wdata[k*BEAT_WIDTH +: BEAT_WIDTH]);
                    k++;
                    if (k == BEATS) begin
                        if (cur_is_write) mem[cur_addr] = cur_wdata;
                        k = 0;
                    end
                end
            end else begin
                // Noise on the ack line while no burst is active must be ignored.
                dram_resp  = ($urandom_range(0, 1) == 1);
                dram_rdata = {$urandom, $urandom};
            end
        end
    end

    // Scoreboard monitor.
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && pmem_resp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got pmem_resp=1 expected no response");
                end else begin
                    e = exp_q.pop_front();
                    check_line(e.is_write ? "wr_keeps_rdata" : "rd_line", pmem_rdata, e.line);
                end
            end
        end
    end

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pmem_resp && n < MAX_WAIT);
        if (!pmem_resp) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no pmem_resp expected one within %0d cycles", MAX_WAIT);
            exp_q.delete();
        end
    endtask

    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input line_t wdata, input bit hold_extra, input bit chk_lat);
        int n;
        @(negedge clk);
        cur_is_write = wr;
        cur_addr     = addr;
        cur_wdata    = wdata;
        if (wr) begin
            exp_q.push_back('{1'b1, last_rd});
        end else begin
            cur_line = mem_get(addr);
            last_rd  = cur_line;
            exp_q.push_back('{1'b0, cur_line});
        end
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wdata;
        wait_resp(n);
        if (chk_lat) check_val("latency", 64'(n), 64'(BEATS + 1));
        if (hold_extra && !wr) begin
            // Still high in the IDLE cycle after DONE: one more accept of the same read.
            exp_q.push_back('{1'b0, cur_line});
            @(negedge clk);
            @(negedge clk);
            pmem_read = 1'b0;
            wait_resp(n);
        end
        @(negedge clk);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;
        int kind;

        // Reset with random inputs.
        rst_n        = 1'b0;
        pmem_read    = 1'($urandom);
        pmem_write   = 1'($urandom);
        pmem_address = $urandom;
        pmem_wdata   = rand_line();
        repeat (3) @(negedge clk);
        check_val("rst_ctrl", {61'd0, pmem_resp, dram_read, dram_write}, 64'd0);
        check_val("rst_addr", 64'(dram_address), 64'd0);
        check_val("rst_wdata", dram_wdata, 64'd0);
        check_line("rst_rdata", pmem_rdata, '0);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        rst_n      = 1'b1;
        repeat (4) @(negedge clk);
        check_val("idle_ctrl", {61'd0, pmem_resp, dram_read, dram_write}, 64'd0);

        // Zero-wait read with known beats.
        ack_mode = 1;
        mem[32'h0000_1240] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_txn(1'b0, 1'b1, 32'h0000_1240, '0, 1'b0, 1'b1);
        check_line("rd_1240_const", pmem_rdata,
                   {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Stalled write, then simultaneous read+write.
        ack_mode = 2;
        do_txn(1'b1, 1'b0, 32'h0000_2000, rand_line(), 1'b0, 1'b0);
        ack_mode = 0;
        do_txn(1'b1, 1'b1, 32'h0000_2020, rand_line(), 1'b0, 1'b0);
        do_txn(1'b0, 1'b1, 32'h0000_2000, '0, 1'b0, 1'b0);

        // Held-over read and back-to-back reads.
        ack_mode = 1;
        do_txn(1'b0, 1'b1, 32'h0000_0100, '0, 1'b1, 1'b1);
        do_txn(1'b0, 1'b1, 32'h0000_0120, '0, 1'b0, 1'b1);

        // Reset in the middle of a read burst.
        ack_limit = 2;
        @(negedge clk);
        cur_is_write = 1'b0;
        cur_addr     = 32'h0000_3000;
        cur_line     = mem_get(32'h0000_3000);
        pmem_address = 32'h0000_3000;
        pmem_read    = 1'b1;
        n = 0;
        while (k < 2 && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_beats_acked", 64'(k), 64'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_ctrl", {61'd0, pmem_resp, dram_read, dram_write}, 64'd0);
        check_line("async_rst_rdata", pmem_rdata, '0);
        pmem_read = 1'b0;
        last_rd   = '0;
        ack_limit = BEATS;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        do_txn(1'b0, 1'b1, 32'h0000_3000, '0, 1'b0, 1'b1);

        // Randomised traffic over a small address window.
        for (int t = 0; t < 30; t++) begin
            ack_mode = $urandom_range(0, 2);
            a        = 32'h0000_4000 + ({27'd0, 5'($urandom_range(0, 7))} << 5);
            kind     = $urandom_range(0, 3);
            case (kind)
                0: do_txn(1'b0, 1'b1, a, '0, 1'b0, ack_mode == 1);
                1: do_txn(1'b1, 1'b0, a, rand_line(), 1'b0, ack_mode == 1);
                2: do_txn(1'b1, 1'b1, a, rand_line(), 1'b0, ack_mode == 1);
                default: do_txn(1'b0, 1'b1, a, '0, 1'b1, 1'b0);
            endcase
        end

        repeat (5) @(negedge clk);
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pmem_burst_responder

`default_nettype wire
